wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_arb_watchdog.sv | 39 +++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_pkg;

    localparam int CTI_W = 3;
    localparam int WD_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] state_gnt(input arb_state_e st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            GNT0:    g = 2'b01;
            GNT1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - bus watchdog, compiled only with WB_ARB_TIMEOUT_EN
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gnt,
    input  logic       stb,
    input  logic       term,
    output logic       timeout
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count;
    logic [1:0]      gnt_q;

    assign timeout = stb && !term && (count == LIMIT);

    // Any termination, idle strobe, ownership change or expiry restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            gnt_q <= 2'b00;
        end else begin
            gnt_q <= gnt;
            if ((gnt != gnt_q) || timeout || !stb || term) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone arbiter
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_CYC,
    input  logic             m0_STB,
    input  logic             m0_WE,
    input  logic [31:0]      m0_ADR,
    input  logic [31:0]      m0_DAT_O,
    input  logic [CTI_W-1:0] m0_CTI_O,
    output logic             m0_ACK,
    output logic             m0_ERR,
    output logic             m0_RTY,
    output logic [31:0]      m0_DAT_I,

    input  logic             m1_CYC,
    input  logic             m1_STB,
    input  logic             m1_WE,
    input  logic [31:0]      m1_ADR,
    input  logic [31:0]      m1_DAT_O,
    input  logic [CTI_W-1:0] m1_CTI_O,
    output logic             m1_ACK,
    output logic             m1_ERR,
    output logic             m1_RTY,
    output logic [31:0]      m1_DAT_I,

    output logic             s_CYC,
    output logic             s_STB,
    output logic             s_WE,
    output logic [31:0]      s_ADR,
    output logic [31:0]      s_DAT_O,
    output logic [CTI_W-1:0] s_CTI_O,
    input  logic             s_ACK,
    input  logic             s_ERR,
    input  logic             s_RTY,
    input  logic [31:0]      s_DAT_I,

    output logic [1:0]       gnt
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    arb_state_e state;
    logic       last;
    logic       sel0;
    logic       sel1;
    logic       stb_raw;
    logic       timeout;

    // last=1 means m1 was served most recently, so m0 wins the next tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_CYC && (!m1_CYC || last)) begin
                        state <= GNT0;
                    end else if (m1_CYC) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_CYC) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_CYC) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt     = state_gnt(state);
    assign sel0    = (state == GNT0);
    assign sel1    = (state == GNT1);
    assign stb_raw = (sel0 & m0_STB) | (sel1 & m1_STB);

`ifdef WB_ARB_TIMEOUT_EN
    logic term;
    assign term = s_ACK | s_ERR | s_RTY;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .gnt    (gnt),
        .stb    (stb_raw),
        .term   (term),
        .timeout(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        s_CYC   = 1'b0;
        s_WE    = 1'b0;
        s_ADR   = '0;
        s_DAT_O = '0;
        s_CTI_O = '0;
        if (sel0) begin
            s_CYC   = m0_CYC;
            s_WE    = m0_WE;
            s_ADR   = m0_ADR;
            s_DAT_O = m0_DAT_O;
            s_CTI_O = m0_CTI_O;
        end else if (sel1) begin
            s_CYC   = m1_CYC;
            s_WE    = m1_WE;
            s_ADR   = m1_ADR;
            s_DAT_O = m1_DAT_O;
            s_CTI_O = m1_CTI_O;
        end
        // The expiring strobe is withdrawn from the bus in the same cycle the error is issued
        s_STB = stb_raw & ~timeout;
    end

    assign m0_ACK   = sel0 & s_ACK;
    assign m0_ERR   = sel0 & (s_ERR | timeout);
    assign m0_RTY   = sel0 & s_RTY;
    assign m0_DAT_I = sel0 ? s_DAT_I : '0;

    assign m1_ACK   = sel1 & s_ACK;
    assign m1_ERR   = sel1 & (s_ERR | timeout);
    assign m1_RTY   = sel1 & s_RTY;
    assign m1_DAT_I = sel1 ? s_DAT_I : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with a behavioural ownership model
module tb_wb_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cyc, stb, we, ack, err, rty;
    logic [31:0] adr [2];
    logic [31:0] dat_o [2];
    logic [2:0]  cti [2];
    logic [31:0] dat_i [2];
    logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [31:0] s_adr, s_dato, s_dati;
    logic [2:0]  s_cti;
    logic [1:0]  gnt;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_CYC(cyc[0]), .m0_STB(stb[0]), .m0_WE(we[0]), .m0_ADR(adr[0]),
        .m0_DAT_O(dat_o[0]), .m0_CTI_O(cti[0]), .m0_ACK(ack[0]), .m0_ERR(err[0]),
        .m0_RTY(rty[0]), .m0_DAT_I(dat_i[0]),
        .m1_CYC(cyc[1]), .m1_STB(stb[1]), .m1_WE(we[1]), .m1_ADR(adr[1]),
        .m1_DAT_O(dat_o[1]), .m1_CTI_O(cti[1]), .m1_ACK(ack[1]), .m1_ERR(err[1]),
        .m1_RTY(rty[1]), .m1_DAT_I(dat_i[1]),
        .s_CYC(s_cyc), .s_STB(s_stb), .s_WE(s_we), .s_ADR(s_adr), .s_DAT_O(s_dato),
        .s_CTI_O(s_cti), .s_ACK(s_ack), .s_ERR(s_err), .s_RTY(s_rty), .s_DAT_I(s_dati),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cyc, stb, we;
        logic [31:0] adr, dat;
        logic [2:0]  cti;
        logic [1:0]  ack, err, rty;
        logic [31:0] dat0, dat1;
    } exp_t;

    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   owner  = -1;   // master currently owning the bus, -1 when nobody does
    int   last   = 1;    // master served most recently
    int   wd     = 0;    // consecutive unanswered strobe cycles of the owner
    int   hold [2];
    int   pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   o;
        logic sr, tmo, term;
        e    = '0;
        o    = rst ? owner : -1;
        term = s_ack | s_err | s_rty;
        if (o >= 0) begin
            sr  = stb[o];
            tmo = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo = sr && !term && (wd == TO - 1);
`endif
            e.gnt    = (o == 0) ? 2'b01 : 2'b10;
            e.cyc    = cyc[o];
            e.stb    = sr & ~tmo;
            e.we     = we[o];
            e.adr    = adr[o];
            e.dat    = dat_o[o];
            e.cti    = cti[o];
            e.ack[o] = s_ack;
            e.err[o] = s_err | tmo;
            e.rty[o] = s_rty;
            if (o == 0) e.dat0 = s_dati;
            else        e.dat1 = s_dati;
        end
        return e;
    endfunction

    task automatic update_model();
        logic term;
        term = s_ack | s_err | s_rty;
        if (!rst) begin
            owner = -1;
            last  = 1;
            wd    = 0;
        end else begin
            if (owner >= 0 && stb[owner] && !term && wd != TO - 1) wd++;
            else wd = 0;
            if (owner < 0) begin
                if (cyc == 2'b11)  owner = 1 - last;
                else if (cyc[0])   owner = 0;
                else if (cyc[1])   owner = 1;
            end else if (!cyc[owner]) begin
                last  = owner;
                owner = -1;
            end
        end
    endtask

    // Expectation for the current inputs is queued; inputs change 1 ns after the next edge
    task automatic step();
        sb.push_back(predict());
        @(posedge clk);
        update_model();
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt",      32'(gnt),      32'(e.gnt));
            chk("s_CYC",    32'(s_cyc),    32'(e.cyc));
            chk("s_STB",    32'(s_stb),    32'(e.stb));
            chk("s_WE",     32'(s_we),     32'(e.we));
            chk("s_ADR",    s_adr,         e.adr);
            chk("s_DAT_O",  s_dato,        e.dat);
            chk("s_CTI_O",  32'(s_cti),    32'(e.cti));
            chk("m_ACK",    32'(ack),      32'(e.ack));
            chk("m_ERR",    32'(err),      32'(e.err));
            chk("m_RTY",    32'(rty),      32'(e.rty));
            chk("m0_DAT_I", dat_i[0],      e.dat0);
            chk("m1_DAT_I", dat_i[1],      e.dat1);
        end
    end

    initial begin
        cyc = '0; stb = '0; we = '0;
        for (int n = 0; n < 2; n++) begin
            adr[n] = '0; dat_o[n] = '0; cti[n] = '0; hold[n] = 0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dati = '0;
        @(posedge clk); #1;
        step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        rst = 1'b1;
        step();

        // Lone m0 read
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_0100; cti[0] = 3'd0;
        #1 chk("r31_latency", 32'(gnt), 32'd0);
        step();
        s_ack = 1'b1; s_dati = 32'hCAFE_0100;
        #1 chk("r31_gnt", 32'(gnt), 32'b01);
        chk("r31_adr", s_adr, 32'h0000_0100);
        chk("r31_dat", dat_i[0], 32'hCAFE_0100);
        chk("r31_m1_ack", 32'(ack[1]), 32'd0);
        step();
        cyc = '0; stb = '0; s_ack = 1'b0;
        step(); step();

        // Simultaneous requests after reset, then re-request
        rst = 1'b0; step(); rst = 1'b1; step();
        cyc = 2'b11; stb = 2'b11; adr[1] = 32'h0000_0200;
        step();
        #1 chk("r32_first", 32'(gnt), 32'b01);
        cyc[0] = 1'b0; step();
        cyc[0] = 1'b1;
        #1 chk("r32_idle", 32'(gnt), 32'b00);
        step();
        #1 chk("r32_rr", 32'(gnt), 32'b10);
        cyc = '0; stb = '0; step(); step();

        // m1 burst while m0 waits
        cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; step();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1; adr[1] = 32'h300 + 32'(b * 4);
            if (b == 3) cti[1] = 3'b111;
            #1 chk("r33_hold", 32'(gnt), 32'b10);
            chk("r33_m0_ack", 32'(ack[0]), 32'd0);
            step();
        end
        s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; step();
        #1 chk("r33_gap", 32'(gnt), 32'b00);
        step();
        #1 chk("r33_m0", 32'(gnt), 32'b01);

        // Reset pulse during an m0 write
        we[0] = 1'b1; adr[0] = 32'h0000_1104; dat_o[0] = 32'h1234_5678; s_ack = 1'b1;
        #1 rst = 1'b0;
        #1 chk("r34_cyc", 32'(s_cyc), 32'd0);
        chk("r34_stb", 32'(s_stb), 32'd0);
        chk("r34_gnt", 32'(gnt), 32'd0);
        chk("r34_ack", 32'(ack[0]), 32'd0);
        step();
        rst = 1'b1; cyc = '0; stb = '0; we = '0; s_ack = 1'b0;
        step();
        #1 chk("r34_idle", 32'(gnt), 32'd0);
        step();

        // Unanswered strobes to 0x2000, then a decoder error
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_2000;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            #1 if (err[0]) pulses++;
            step();
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("r35_timeout_pulses", 32'(pulses), 32'd1);
`else
        chk("r36_no_timeout", 32'(pulses), 32'd0);
`endif
        s_err = 1'b1;
        #1 chk("r36_err_route", 32'(err[0]), 32'd1);
        step();
        s_err = 1'b0; cyc = '0; stb = '0; step(); step();

        // Randomised traffic, occasional resets
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (cyc[n]) begin
                    if (hold[n] == 0) cyc[n] = 1'b0;
                    else hold[n]--;
                end else if ($urandom_range(2) == 0) begin
                    cyc[n]  = 1'b1;
                    hold[n] = int'($urandom_range(8));
                end
                stb[n]   = cyc[n] & ($urandom_range(3) != 0);
                we[n]    = 1'($urandom_range(1));
                adr[n]   = $urandom;
                dat_o[n] = $urandom;
                cti[n]   = 3'($urandom_range(7));
            end
            s_ack  = 1'($urandom_range(1));
            s_err  = ($urandom_range(7) == 0);
            s_rty  = ($urandom_range(7) == 0);
            s_dati = $urandom;
            rst    = ($urandom_range(149) != 0);
            step();
        end
        rst = 1'b1; cyc = '0; stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        step(); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
